// File: rtl/fadd_issue.sv
// fadd_issue: issue/response wrapper around a fixed-latency (2) floating-point
// adder that has no stall input. Requests are only accepted when a slot is
// guaranteed in the 4-entry result FIFO, so adder results can always be
// captured on the cycle they appear.
// Optional feature macro: FADD_ISSUE_TAG_EN adds a 4-bit request/response tag.
module fadd_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
`ifdef FADD_ISSUE_TAG_EN
  input  logic [3:0]  req_tag,
  output logic [3:0]  rsp_tag,
`endif
  output logic [31:0] fa_x1,
  output logic [31:0] fa_x2,
  input  logic [31:0] fa_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_y,
  output logic        busy
);

  localparam int DATA_W = 32;

  logic              accept;
  logic              pop;
  logic              vld_p1;
  logic              vld_p2;
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        occ;
  logic [2:0]        pending;
  logic [DATA_W-1:0] fifo_y [4];

`ifdef FADD_ISSUE_TAG_EN
  logic [3:0]        tag_p1;
  logic [3:0]        tag_p2;
  logic [3:0]        fifo_tag [4];
`endif

  // Operand path: subtraction is an add with b's sign flipped.
  assign fa_x1 = req_a;
  assign fa_x2 = {req_b[31] ^ req_op, req_b[30:0]};

  // Admission counts results already buffered plus those still inside the
  // adder, so a result arriving from the adder always has a free FIFO slot.
  assign pending   = occ + {2'b00, vld_p1} + {2'b00, vld_p2};
  assign req_ready = !rst && (pending < 3'd4);
  assign accept    = req_valid && req_ready;

  assign rsp_valid = (occ != 3'd0);
  assign pop       = rsp_valid && rsp_ready;
  // Head is forced to zero when empty so outputs are clean after reset.
  assign rsp_y     = rsp_valid ? fifo_y[rd_ptr] : '0;
`ifdef FADD_ISSUE_TAG_EN
  assign rsp_tag   = rsp_valid ? fifo_tag[rd_ptr] : 4'd0;
`endif

  assign busy = vld_p1 | vld_p2 | (occ != 3'd0);

  // Control state: in-flight valid shift register, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 3'd0;
    end else begin
      // stage p1 -> p2: adder result lands while vld_p2 is high
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
      if (vld_p2) wr_ptr <= wr_ptr + 2'd1;
      if (pop)    rd_ptr <= rd_ptr + 2'd1;
      case ({vld_p2, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Result storage: capture adder output into the tail slot (data, no reset).
  always_ff @(posedge clk) begin
    if (vld_p2) fifo_y[wr_ptr] <= fa_y;
  end

`ifdef FADD_ISSUE_TAG_EN
  // Tag travels alongside the adder pipeline and is stored with its result.
  always_ff @(posedge clk) begin
    // stage p1 -> p2 -> FIFO
    tag_p1 <= req_tag;
    tag_p2 <= tag_p1;
    if (vld_p2) fifo_tag[wr_ptr] <= tag_p2;
  end
`endif

endmodule
